// File: rtl/pll_pkg.sv
// pll_pkg: shared types and constants for the PLL reset sequencer.
//   seq_state_t  - sequencer state encoding
//   DEF_*        - default timing constants (cycles of the 50 MHz refclk)
//   RELOCK_W     - width of the relock diagnostic counter
//   max4()       - largest of four values, used to size the shared counter
//   sat_inc()    - saturating increment of a relock counter value
package pll_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        CORE_RST  = 3'd4
    } seq_state_t;

    localparam int DEF_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT    = 500000;
    localparam int DEF_SETTLE_CYCLES   = 1024;
    localparam int DEF_CORE_RST_CYCLES = 256;

    localparam int RELOCK_W = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        if (v == {RELOCK_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(RELOCK_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// sync2: generic two-flop bit synchronizer.
//   clk  in  destination clock
//   rst  in  synchronous active-high reset, forces the chain to RST_VAL
//   d    in  asynchronous input bit
//   q    out synchronized bit, two clk cycles behind d
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture chain; the first stage may go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset sequencer for the core PLL, clocked by the 50 MHz
// reference so it keeps running while the PLL is unlocked.
//   refclk        in  reference clock (only clock)
//   rst           in  synchronous active-high reset
//   pll_locked    in  asynchronous PLL lock indication
//   reset_req     in  core-reset request (level, refclk domain)
//   pll_rst       out reset to the PLL
//   core_reset    out reset to all logic on the PLL output clocks
//   ready         out high only while running with a stable lock
//   relock_count  out saturating count of lock losses seen while running
module pll_reset_seq
    import pll_pkg::*;
#(
    parameter int RST_CYCLES      = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int CORE_RST_CYCLES = DEF_CORE_RST_CYCLES
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                reset_req,
    output logic                pll_rst,
    output logic                core_reset,
    output logic                ready,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int CNT_W = $clog2(max4(RST_CYCLES, LOCK_TIMEOUT,
                                       SETTLE_CYCLES, CORE_RST_CYCLES)) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    // Counter reload values: the counter runs down to zero, so the last
    // cycle of a phase is the one where it reads zero.
    localparam cnt_t CNT_ZERO    = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t RST_LOAD    = cnt_t'(RST_CYCLES - 32'sd1);
    localparam cnt_t LOCK_LOAD   = cnt_t'(LOCK_TIMEOUT - 32'sd1);
    localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYCLES - 32'sd1);
    localparam cnt_t CORE_LOAD   = cnt_t'(CORE_RST_CYCLES - 32'sd1);

    seq_state_t          state_r;
    seq_state_t          state_s;
    cnt_t                cnt_r;
    cnt_t                cnt_s;
    logic [RELOCK_W-1:0] relock_s;
    logic                lk_s;

    sync2 #(.RST_VAL(1'b0)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    // Next-state, counter and relock-count decisions. Lock loss is checked
    // first in RUN/CORE_RST so it wins over a pending core-reset request.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        relock_s = relock_count;
        case (state_r)
            PLL_RST: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = LOCK_LOAD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_s = SETTLE;
                    cnt_s   = SETTLE_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = PLL_RST;
                    cnt_s   = RST_LOAD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            SETTLE: begin
                if (!lk_s) begin
                    // Lock bounced: restart the full lock timeout.
                    state_s = WAIT_LOCK;
                    cnt_s   = LOCK_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_s  = PLL_RST;
                    cnt_s    = RST_LOAD;
                    relock_s = sat_inc(relock_count);
                end else if (reset_req) begin
                    state_s = CORE_RST;
                    cnt_s   = CORE_LOAD;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            CORE_RST: begin
                if (!lk_s) begin
                    state_s  = PLL_RST;
                    cnt_s    = RST_LOAD;
                    relock_s = sat_inc(relock_count);
                end else if (cnt_r != CNT_ZERO) begin
                    // Minimum hold keeps counting even while the request is held.
                    cnt_s = cnt_r - CNT_ONE;
                end else if (!reset_req) begin
                    state_s = RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = PLL_RST;
                cnt_s   = RST_LOAD;
            end
        endcase
    end

    // State, counter and registered outputs; outputs are decoded from the
    // next state so they change on the same edge as the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r      <= PLL_RST;
            cnt_r        <= RST_LOAD;
            relock_count <= {RELOCK_W{1'b0}};
            pll_rst      <= 1'b1;
            core_reset   <= 1'b1;
            ready        <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            relock_count <= relock_s;
            pll_rst      <= (state_s == PLL_RST);
            core_reset   <= (state_s != RUN);
            ready        <= (state_s == RUN);
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed scenarios plus random stimulus for
// pll_reset_seq, checked every cycle against a phase/elapsed-time model.
module tb_pll_reset_seq;

    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int SET_C = 8;
    localparam int CR_C  = 5;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       reset_req;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic [7:0] relock_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase name, cycle of phase entry, relock count and
    // the history of sampled pll_locked values.
    string m_phase;
    int    m_entry;
    int    m_relock;
    bit    hist[$];

    pll_reset_seq #(
        .RST_CYCLES      (RST_C),
        .LOCK_TIMEOUT    (TO_C),
        .SETTLE_CYCLES   (SET_C),
        .CORE_RST_CYCLES (CR_C)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .reset_req    (reset_req),
        .pll_rst      (pll_rst),
        .core_reset   (core_reset),
        .ready        (ready),
        .relock_count (relock_count)
    );

    // 50 MHz reference clock.
    always #10 refclk = ~refclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void enter(input string p);
        m_phase = p;
        m_entry = cyc + 1;
    endfunction

    function automatic void lost_lock();
        enter("pll_rst");
        if (m_relock < 255) m_relock++;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    function automatic void model_step();
        bit lk;
        int spent;
        if (rst) begin
            enter("pll_rst");
            m_relock = 0;
            hist = '{1'b0, 1'b0};
            return;
        end
        lk = hist[hist.size()-2];
        hist.push_back(pll_locked);
        if (hist.size() > 4) void'(hist.pop_front());
        spent = cyc - m_entry + 1;
        if (m_phase == "pll_rst") begin
            if (spent >= RST_C) enter("wait");
        end else if (m_phase == "wait") begin
            if (lk) enter("settle");
            else if (spent >= TO_C) enter("pll_rst");
        end else if (m_phase == "settle") begin
            if (!lk) enter("wait");
            else if (spent >= SET_C) enter("run");
        end else if (m_phase == "run") begin
            if (!lk) lost_lock();
            else if (reset_req) enter("core");
        end else begin
            if (!lk) lost_lock();
            else if (spent >= CR_C && !reset_req) enter("run");
        end
    endfunction

    task automatic tick();
        @(posedge refclk);
        model_step();
        cyc++;
        @(negedge refclk);
        check_val("pll_rst", pll_rst, m_phase == "pll_rst");
        check_val("core_reset", core_reset, m_phase != "run");
        check_val("ready", ready, m_phase == "run");
        check_val("relock_count", relock_count, m_relock);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 200 && !ready; k++) tick();
        check_val("wait_ready", ready, 1);
    endtask

    task automatic lose_lock();
        pll_locked = 1'b0;
        tick();
        check_val("loss_c1_pll_rst", pll_rst, 0);
        tick();
        check_val("loss_c2_pll_rst", pll_rst, 0);
        tick();
        check_val("loss_c3_pll_rst", pll_rst, 1);
        check_val("loss_c3_core_reset", core_reset, 1);
        pll_locked = 1'b1;
        wait_ready();
    endtask

    initial begin
        int c0;
        int first;
        int n;
        int last_rise;
        logic prev;

        rst        = 1'b1;
        pll_locked = 1'b0;
        reset_req  = 1'b0;
        m_phase    = "pll_rst";
        m_entry    = 0;
        m_relock   = 0;
        hist       = '{1'b0, 1'b0};
        @(negedge refclk);
        for (int i = 0; i < 3; i++) tick();

        // Clean start: lock at cycle 10, release expected at cycle 21.
        rst   = 1'b0;
        c0    = cyc;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            check_val("start_pll_rst", pll_rst, (i < RST_C));
            if (!core_reset && first < 0) first = cyc - c0;
            if (i == 10) pll_locked = 1'b1;
            tick();
        end
        check_val("start_release_cycle", first, 21);

        // Lock losses in RUN.
        lose_lock();
        check_val("relock_after_1", relock_count, 1);
        lose_lock();
        lose_lock();
        check_val("relock_after_3", relock_count, 3);

        // Mid-operation reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_pll_rst", pll_rst, 1);
        check_val("midrst_core_reset", core_reset, 1);
        check_val("midrst_ready", ready, 0);
        check_val("midrst_relock", relock_count, 0);

        // Lock bounce during SETTLE: drop in cycle 8, restore in cycle 9.
        c0    = cyc;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            if (ready && first < 0) first = cyc - c0;
            if (i == 8) pll_locked = 1'b0;
            if (i == 9) pll_locked = 1'b1;
            tick();
        end
        check_val("bounce_ready_cycle", first, 20);
        check_val("bounce_relock", relock_count, 0);

        // Single-cycle core-reset request.
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        n = 0;
        while (core_reset && n < 50) begin
            n++;
            tick();
        end
        check_val("req_pulse_width", n, CR_C);

        // Request held for 12 cycles.
        wait_ready();
        reset_req = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        reset_req = 1'b0;
        check_val("req_hold_still", core_reset, 1);
        tick();
        check_val("req_hold_release", core_reset, 0);

        // Lock loss during CORE_RST.
        reset_req = 1'b1;
        tick();
        reset_req  = 1'b0;
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        check_val("core_loss_pll_rst", pll_rst, 1);
        check_val("core_loss_relock", relock_count, 1);
        pll_locked = 1'b1;
        wait_ready();

        // No lock: periodic PLL reset pulses, core never released.
        pll_locked = 1'b0;
        prev       = pll_rst;
        last_rise  = -1;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (pll_rst && !prev) begin
                if (last_rise >= 0) check_val("nolock_period", cyc - last_rise, RST_C + TO_C);
                last_rise = cyc;
            end
            if (!pll_rst && prev) check_val("nolock_width", cyc - last_rise, RST_C);
            if (i >= 2) check_val("nolock_core_reset", core_reset, 1);
            prev = pll_rst;
        end
        pll_locked = 1'b1;
        wait_ready();

        // Saturation of the relock counter.
        for (int i = 0; i < 300; i++) lose_lock();
        check_val("relock_saturated", relock_count, 255);

        // Random stimulus.
        for (int i = 0; i < 4000; i++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 79) == 0) pll_locked = 1'b0;
            end else begin
                if ($urandom_range(0, 24) == 0) pll_locked = 1'b1;
            end
            reset_req = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst       = 1'b0;
        reset_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time bound.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
